pc_unit: RTL and testbench

Parametrised program-counter unit for the instruction-fetch stage. It generalises the single-register PC:
- configurable address width, step and reset/exception vectors;
- prioritised next-PC selection (exception, jump, branch, return, sequential);
- a pending-redirect register so redirects raised during a stall are not lost;
- an optional return-address stack.

It drives the instruction-memory address and the sequential-address adder output.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_unit.sv | 160 ++++++++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Shared next-PC source encoding and default parameters for pc_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int c_def_addr_w    = 10;
    localparam int c_def_step      = 1;
    localparam int c_def_reset_vec = 0;
    localparam int c_def_exc_vec   = 'h3F0;
    localparam int c_def_ras_depth = 4;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_RET  = 3'd1,
        SRC_BR   = 3'd2,
        SRC_JMP  = 3'd3,
        SRC_PEND = 3'd4,
        SRC_EXC  = 3'd5
    } pc_src_e;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module : pc_ras
// Brief  : Circular return-address stack; a push when full overwrites the
//          oldest entry. State updates on the falling clock edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_replace,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_empty,
    output logic              o_full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_ptr_w-1:0] w_ptr_inc;

    // DEPTH is a power of two, so the pointer wraps on its own.
    assign w_ptr_inc = r_ptr + 1'b1;
    assign o_top     = r_mem[r_ptr];
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == c_cnt_w'(DEPTH));

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_ptr <= w_ptr_inc;
            if (!o_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_pop && !o_empty) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Entry storage carries no reset; the count alone decides validity.
    always_ff @(negedge clock) begin
        if (i_push) begin
            r_mem[w_ptr_inc] <= i_data;
        end else if (i_replace) begin
            r_mem[r_ptr] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module : pc_unit
// Brief  : Program counter with prioritised redirect mux, stall-safe pending
//          redirect and optional return-address stack (macro PC_RAS_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = c_def_addr_w,
    parameter int                STEP      = c_def_step,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(c_def_reset_vec),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(c_def_exc_vec),
    parameter int                RAS_DEPTH = c_def_ras_depth
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_write,
    input  logic              exc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_current,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic              redirect_pending,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_tgt;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_pc_target;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_ret_ok;
    pc_src_e           w_src;

    assign w_pc_seq         = r_pc + ADDR_W'(STEP);
    assign pc_current       = r_pc;
    assign pc_next_seq      = w_pc_seq;
    assign redirect_pending = r_pend_vld;
    assign ras_empty        = w_ras_empty;
    assign ras_full         = w_ras_full;

`ifdef PC_RAS_EN
    logic w_push;
    logic w_pop;
    logic w_replace;
    logic w_ras_err_nxt;
    logic r_ras_err;

    // A ret on an empty stack falls through to sequential.
    assign w_ret_ok  = ret & ~w_ras_empty;
    assign w_push    = pc_write & call & (w_src != SRC_RET);
    assign w_pop     = pc_write & ~call & (w_src == SRC_RET);
    assign w_replace = pc_write & call & (w_src == SRC_RET);

    // Flag only a ret that would have won the mux had the stack held data.
    assign w_ras_err_nxt = pc_write & ret & w_ras_empty & ~exc & ~r_pend_vld
                         & ~jump & ~branch_taken;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_replace (w_replace),
        .i_data    (w_pc_seq),
        .o_top     (w_ras_top),
        .o_empty   (w_ras_empty),
        .o_full    (w_ras_full)
    );

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_ras_err <= 1'b0;
        end else begin
            r_ras_err <= w_ras_err_nxt;
        end
    end

    assign ras_err = r_ras_err;
`else
    logic w_unused_ras;

    assign w_ret_ok     = 1'b0;
    assign w_ras_top    = '0;
    assign w_ras_empty  = 1'b1;
    assign w_ras_full   = 1'b0;
    assign ras_err      = 1'b0;
    assign w_unused_ras = call | ret | (RAS_DEPTH > 0);
`endif

    always_comb begin
        w_src = SRC_SEQ;
        if (exc) begin
            w_src = SRC_EXC;
        end else if (r_pend_vld) begin
            w_src = SRC_PEND;
        end else if (jump) begin
            w_src = SRC_JMP;
        end else if (branch_taken) begin
            w_src = SRC_BR;
        end else if (w_ret_ok) begin
            w_src = SRC_RET;
        end
    end

    always_comb begin
        w_pc_target = w_pc_seq;
        case (w_src)
            SRC_EXC:  w_pc_target = EXC_VEC;
            SRC_PEND: w_pc_target = r_pend_tgt;
            SRC_JMP:  w_pc_target = jump_target;
            SRC_BR:   w_pc_target = branch_target;
            SRC_RET:  w_pc_target = w_ras_top;
            default:  w_pc_target = w_pc_seq;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_VEC;
        end else if (pc_write) begin
            r_pc <= w_pc_target;
        end
    end

    // While stalled an exception always takes the slot; otherwise the oldest
    // held redirect is kept.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
        end else if (pc_write) begin
            r_pend_vld <= 1'b0;
        end else if (exc) begin
            r_pend_vld <= 1'b1;
            r_pend_tgt <= EXC_VEC;
        end else if (!r_pend_vld && (jump || branch_taken)) begin
            r_pend_vld <= 1'b1;
            r_pend_tgt <= jump ? jump_target : branch_target;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module : tb_pc_unit
// Brief  : Directed self-checking bench for pc_unit (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic       clock;
    logic       reset;
    logic       pc_write;
    logic       exc;
    logic       jump;
    logic [9:0] jump_target;
    logic       branch_taken;
    logic [9:0] branch_target;
    logic       call;
    logic       ret;
    logic [9:0] pc_current;
    logic [9:0] pc_next_seq;
    logic       redirect_pending;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_err;

    int n_vec = 0;
    int n_err = 0;

    pc_unit u_dut (
        .clock            (clock),
        .reset            (reset),
        .pc_write         (pc_write),
        .exc              (exc),
        .jump             (jump),
        .jump_target      (jump_target),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .call             (call),
        .ret              (ret),
        .pc_current       (pc_current),
        .pc_next_seq      (pc_next_seq),
        .redirect_pending (redirect_pending),
        .ras_empty        (ras_empty),
        .ras_full         (ras_full),
        .ras_err          (ras_err)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, let the falling edge act, then idle inputs.
    task automatic apply(input logic pw, input logic ex, input logic jp, input logic [9:0] jt,
                         input logic br, input logic [9:0] bt, input logic cl, input logic rt);
        pc_write      = pw;
        exc           = ex;
        jump          = jp;
        jump_target   = jt;
        branch_taken  = br;
        branch_target = bt;
        call          = cl;
        ret           = rt;
        @(negedge clock);
        #1;
        pc_write      = 1'b0;
        exc           = 1'b0;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        call          = 1'b0;
        ret           = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pc_write = 0; exc = 0; jump = 0; jump_target = '0;
        branch_taken = 0; branch_target = '0; call = 0; ret = 0;
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        chk("rst_pc", pc_current, 10'h000);
        chk("rst_pend", redirect_pending, 0);
        chk("rst_empty", ras_empty, 1);
        chk("rst_full", ras_full, 0);
        chk("rst_err", ras_err, 0);
        chk("rst_nseq", pc_next_seq, 10'h001);

        apply(1, 0, 0, 0, 0, 0, 0, 0); chk("seq1", pc_current, 10'h001);
        apply(1, 0, 0, 0, 0, 0, 0, 0); chk("seq2", pc_current, 10'h002);
        apply(1, 0, 0, 0, 0, 0, 0, 0); chk("seq3", pc_current, 10'h003);

        // Redirect raised during a stall must survive and beat a newer branch.
        apply(0, 0, 1, 10'h080, 0, 0, 0, 0);
        chk("stall_hold", pc_current, 10'h003);
        chk("stall_pend", redirect_pending, 1);
        apply(1, 0, 0, 0, 1, 10'h100, 0, 0);
        chk("pend_pc", pc_current, 10'h080);
        chk("pend_clr", redirect_pending, 0);
        apply(1, 0, 0, 0, 1, 10'h100, 0, 0);
        chk("branch", pc_current, 10'h100);

        apply(1, 1, 1, 10'h080, 1, 10'h200, 0, 0);
        chk("exc_prio", pc_current, 10'h3F0);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("exc_seq", pc_current, 10'h3F1);

        // Exception during stall overwrites the held jump.
        apply(0, 0, 1, 10'h080, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 0);
        chk("exc_stall_hold", pc_current, 10'h3F1);
        chk("exc_stall_pend", redirect_pending, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("exc_stall_pc", pc_current, 10'h3F0);

        apply(0, 0, 1, 10'h080, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 10'h200, 0, 0);
        chk("older_pend", redirect_pending, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("older_wins", pc_current, 10'h080);

        // Asynchronous reset mid-stall drops the pending redirect.
        apply(0, 0, 1, 10'h055, 0, 0, 0, 0);
        chk("pre_rst_pend", redirect_pending, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pc", pc_current, 10'h000);
        chk("async_rst_pend", redirect_pending, 0);
        chk("async_rst_empty", ras_empty, 1);
        #1 reset = 1'b0;
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst", pc_current, 10'h001);

        apply(1, 0, 1, 10'h3FF, 0, 0, 0, 0);
        chk("wrap_top", pc_current, 10'h3FF);
        chk("wrap_nseq", pc_next_seq, 10'h000);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap", pc_current, 10'h000);

`ifdef PC_RAS_EN
        apply(1, 0, 1, 10'h010, 0, 0, 0, 0);
        apply(1, 0, 1, 10'h020, 0, 0, 1, 0);
        chk("call1_pc", pc_current, 10'h020);
        chk("call1_empty", ras_empty, 0);
        apply(1, 0, 1, 10'h040, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        chk("ret1", pc_current, 10'h021);
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        chk("ret2", pc_current, 10'h011);
        chk("ret2_empty", ras_empty, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        chk("ret_empty_pc", pc_current, 10'h012);
        chk("ret_empty_err", ras_err, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("err_pulse", ras_err, 0);
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0, 0, 0, 1, 0);
            if (i >= 3) chk("full", ras_full, 1);
        end
        chk("five_calls_pc", pc_current, 10'h018);
        apply(1, 0, 0, 0, 0, 0, 0, 1); chk("pop_a", pc_current, 10'h018);
        apply(1, 0, 0, 0, 0, 0, 0, 1); chk("pop_b", pc_current, 10'h017);
        apply(1, 0, 0, 0, 0, 0, 0, 1); chk("pop_c", pc_current, 10'h016);
        apply(1, 0, 0, 0, 0, 0, 0, 1); chk("pop_d", pc_current, 10'h015);
        chk("oldest_gone", ras_empty, 1);
        apply(1, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 1, 1);
        chk("callret_pc", pc_current, 10'h016);
        chk("callret_cnt", ras_empty, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        chk("callret_top", pc_current, 10'h017);
        chk("callret_empty", ras_empty, 1);
`else
        apply(1, 0, 1, 10'h050, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        chk("noras_ret", pc_current, 10'h051);
        chk("noras_empty", ras_empty, 1);
        chk("noras_err", ras_err, 0);
        apply(1, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        chk("noras_callret", pc_current, 10'h053);
        chk("noras_full", ras_full, 0);
        chk("noras_empty2", ras_empty, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
